// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: default geometry, address split and FSM states.
package cpu_types_pkg;

    localparam int unsigned ICACHE_SETS_DEFAULT = 16;
    localparam int unsigned ICACHE_IDX_W        = $clog2(ICACHE_SETS_DEFAULT);
    localparam int unsigned ICACHE_TAG_W        = 30 - ICACHE_IDX_W;

    // Fetch address split for the default geometry.
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE,
        MISS
    } icache_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped frame storage: valid/tag/data per frame, one combinational read port and
// one synchronous write port. Only the valid bits are reset.
module icache_array
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS  = ICACHE_SETS_DEFAULT,
    parameter int unsigned IDX_W = $clog2(SETS),
    parameter int unsigned TAG_W = 30 - IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-frame instruction cache with zero-cycle hits and blocking refill.
// Define ICACHE_STATS_EN to build saturating hit/miss counters; otherwise they read as 0.
module icache
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS = ICACHE_SETS_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    icache_state_t state_q, state_d;

    logic [29:0]      miss_word_q;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_data;
    logic             lookup_hit;
    logic             miss_start;
    logic             fill_en;
    logic             unused_bytoff;

    assign req_idx       = imemaddr[IDX_W+1:2];
    assign req_tag       = imemaddr[31:IDX_W+2];
    assign unused_bytoff = ^imemaddr[1:0];

    icache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk_i      (CLK),
        .rst_i      (RST),
        .rd_idx_i   (req_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (fill_en),
        .wr_idx_i   (miss_word_q[IDX_W-1:0]),
        .wr_tag_i   (miss_word_q[29:IDX_W]),
        .wr_data_i  (iload)
    );

    assign lookup_hit = imemREN && rd_valid && (rd_tag == req_tag);
    assign miss_start = (state_q == IDLE) && imemREN && !lookup_hit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (miss_start) state_d = MISS;
            MISS:    if (!iwait)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        fill_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                ihit     = lookup_hit;
                imemload = lookup_hit ? rd_data : '0;
            end
            MISS: begin
                iREN    = 1'b1;
                iaddr   = {miss_word_q, 2'b00};
                fill_en = !iwait;
            end
            default: ;
        endcase
    end

    // The fill always targets the address captured at miss time, even if the PC moves on.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            miss_word_q <= '0;
        end else if (miss_start) begin
            miss_word_q <= imemaddr[31:2];
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (ihit && hit_count_q != 32'hFFFF_FFFF) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_start && miss_count_q != 32'hFFFF_FFFF) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: fills, hits, conflicts, mid-miss PC changes, reset.
module tb_icache;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

`ifdef ICACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    icache #(
        .SETS (16)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Step over a cycle in which the bench expects ihit to be high.
    task automatic step_hit();
        exp_hits++;
        step();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_hit_count"}, hit_count, STATS ? 32'(exp_hits) : 32'd0);
        check({tag, "_miss_count"}, miss_count, STATS ? 32'(exp_miss) : 32'd0);
    endtask

    // Starts from IDLE with addr missing; serves the refill after `waits` busy cycles.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] data, input int waits);
        logic [31:0] word_addr;
        word_addr = {addr[31:2], 2'b00};
        imemaddr  = addr;
        imemREN   = 1'b1;
        iwait     = 1'b1;
        #1;
        check("miss_ihit", ihit, 32'd0);
        check("miss_idle_iren", iREN, 32'd0);
        step();
        exp_miss++;
        for (int i = 0; i < waits; i++) begin
            #1;
            check("busy_iren", iREN, 32'd1);
            check("busy_iaddr", iaddr, word_addr);
            check("busy_ihit", ihit, 32'd0);
            step();
        end
        iwait = 1'b0;
        iload = data;
        #1;
        check("fill_iren", iREN, 32'd1);
        check("fill_iaddr", iaddr, word_addr);
        step();
        iwait = 1'b1;
        iload = 32'hDEAD_BEEF;
        #1;
        check("post_fill_ihit", ihit, 32'd1);
        check("post_fill_data", imemload, data);
        check("post_fill_iren", iREN, 32'd0);
    endtask

    initial begin
        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = '0;
        iwait    = 1'b1;
        iload    = '0;
        repeat (2) @(posedge CLK);
        #2;
        check("rst_ihit", ihit, 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_iren", iREN, 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check_counts("rst");
        RST = 1'b0;

        // First fetch misses, three busy cycles, then hits the cycle after the fill.
        do_miss(32'h0000_0000, 32'h2001_0004, 3);
        step_hit();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("refetch_ihit", ihit, 32'd1);
            check("refetch_data", imemload, 32'h2001_0004);
            check("refetch_iren", iREN, 32'd0);
            check("refetch_iaddr", iaddr, 32'd0);
            step_hit();
        end
        check_counts("one_miss");

        imemREN = 1'b0;
        #1;
        check("noreq_ihit", ihit, 32'd0);
        check("noreq_imemload", imemload, 32'd0);
        check("noreq_iren", iREN, 32'd0);
        step();

        // Same index, new tag: replaces frame 0, so the old address misses again.
        do_miss(32'h0000_0040, 32'hAAAA_0040, 1);
        step_hit();
        do_miss(32'h0000_0000, 32'h2001_0004, 0);
        step_hit();

        // PC moves during the refill; the fill still lands on the latched address.
        imemaddr = 32'h0000_0010;
        #1;
        check("sw_idle_ihit", ihit, 32'd0);
        step();
        exp_miss++;
        imemaddr = 32'h0000_0020;
        #1;
        check("sw_iaddr_held", iaddr, 32'h0000_0010);
        check("sw_ihit", ihit, 32'd0);
        step();
        iwait = 1'b0;
        iload = 32'h1111_0010;
        #1;
        check("sw_fill_iaddr", iaddr, 32'h0000_0010);
        step();
        iwait = 1'b1;
        do_miss(32'h0000_0020, 32'h2222_0020, 1);
        step_hit();
        imemaddr = 32'h0000_0013;
        #1;
        check("sw_idx4_ihit", ihit, 32'd1);
        check("sw_idx4_data", imemload, 32'h1111_0010);
        step_hit();
        imemaddr = 32'h0000_0000;
        #1;
        check("idx0_still_ihit", ihit, 32'd1);
        step_hit();
        check_counts("pre_rst");

        // Reset in the middle of a refill drops it and invalidates every frame.
        imemaddr = 32'h0000_0040;
        #1;
        check("rstmiss_ihit", ihit, 32'd0);
        step();
        #1;
        check("rstmiss_iren_before", iREN, 32'd1);
        RST = 1'b1;
        #1;
        check("rstmiss_iren", iREN, 32'd0);
        check("rstmiss_iaddr", iaddr, 32'd0);
        check("rstmiss_ihit", ihit, 32'd0);
        exp_hits = 0;
        exp_miss = 0;
        check_counts("rstmiss");
        step();
        RST      = 1'b0;
        imemaddr = 32'h0000_0010;
        #1;
        check("post_rst_0x10_ihit", ihit, 32'd0);
        imemaddr = 32'h0000_0020;
        #1;
        check("post_rst_0x20_ihit", ihit, 32'd0);
        do_miss(32'h0000_0000, 32'h3333_0000, 2);
        step_hit();
        check_counts("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter SETS, default 16, number of direct-mapped one-word frames (power of two, 2..256).
REQ-002 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imemREN  input  1  datapath fetch request.
REQ-005 SHALL have port imemaddr  input  32  datapath fetch address (PC).
REQ-006 SHALL have port ihit  output  1  imemload valid for current imemaddr.
REQ-007 SHALL have port imemload  output  32  instruction word to datapath.
REQ-008 SHALL have port iREN  output  1  memory-side read request.
REQ-009 SHALL have port iaddr  output  32  memory-side word address.
REQ-010 SHALL have port iwait  input  1  memory busy; iload valid when low with iREN high.
REQ-011 SHALL have port iload  input  32  memory-side read data.
REQ-012 SHALL have ports hit_count and miss_count, output, 32 each, statistics (see Configuration).

Function
REQ-013 SHALL split imemaddr into tag [31:2+IDX_W], index [1+IDX_W:2], ignored byte offset [1:0]; IDX_W = log2(SETS).
REQ-014 SHALL implement FSM states IDLE and MISS.
REQ-015 In IDLE, ihit SHALL be combinational: imemREN && valid[idx] && tag[idx]==addr tag; imemload = data[idx] when ihit, else 0.
REQ-016 IDLE SHALL go to MISS on imemREN && !hit, latching word-aligned imemaddr into miss register.
REQ-017 In MISS, iREN SHALL be 1 and iaddr SHALL equal the latched miss address; ihit SHALL be 0.
REQ-018 In MISS with iwait=0, the frame at latched index SHALL be written (valid=1, latched tag, iload) and FSM SHALL return to IDLE next cycle.
REQ-019 Hit latency SHALL be 0 cycles; miss latency SHALL be ihit high the cycle after iwait samples low (if imemaddr unchanged).
REQ-020 Changes to imemaddr or deassertion of imemREN during MISS SHALL NOT abort the fill; refill completes to the latched address, then IDLE re-evaluates the current address.
REQ-021 In IDLE, iREN SHALL be 0 and iaddr SHALL be 0.
REQ-022 A conflicting tag at the same index SHALL overwrite the frame (no replacement policy beyond direct mapping).

Reset
REQ-023 RST high SHALL immediately force IDLE, clear all valid bits, clear miss register and counters; ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-024 Tag and data arrays SHALL NOT require reset; RST mid-MISS SHALL discard the fill.

Configuration
REQ-025 With ICACHE_STATS_EN defined, hit_count SHALL increment each cycle ihit=1 and miss_count on each IDLE->MISS transition, both saturating at 0xFFFF_FFFF, reset to 0.
REQ-026 Without ICACHE_STATS_EN, hit_count and miss_count SHALL be constant 0 and no counter flops SHALL be inferred.

Structure
REQ-027 SHALL place icachef_t (tag/idx/bytoff address struct), icache_state_t enum and default SETS constant in cpu_types_pkg.
REQ-028 SHALL use one sub-module, icache_array: frame storage (valid/tag/data) with one combinational read port and one synchronous write port.

Verification
REQ-029 Reset, imemREN=1, imemaddr=0x0000_0000; memory iwait=1 for 3 cycles then iload=0x2001_0004 -> iREN=1, iaddr=0 throughout MISS; ihit=1, imemload=0x2001_0004 next cycle.
REQ-030 Re-fetch 0x0000_0000 -> ihit=1 same cycle, iREN=0, no memory access.
REQ-031 Fetch 0x0000_0040 (idx 0, new tag) -> miss, frame replaced; then 0x0000_0000 -> miss again.
REQ-032 Miss on 0x0000_0010, switch imemaddr to 0x0000_0020 while iwait=1 -> iaddr stays 0x10, fill completes to idx 4; then 0x20 misses with iaddr=0x20.
REQ-033 Assert RST during MISS -> iREN=0 same cycle; following fetch of any prior address misses.
REQ-034 With ICACHE_STATS_EN: one miss then 3 hit cycles -> miss_count=1, hit_count=3 (plus the post-fill hit cycle counted); without macro -> both 0.
